// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole round sequencer.
// Picks a hole from an 8-bit Galois LFSR, lights it, arms the interval timer,
// and resolves each round as a hit or a miss while tracking score and misses.
// Optional feature macro: MOLE_CTRL_NO_REPEAT_EN (no hole repeats across rounds).
module mole_round_ctrl #(
  parameter int NUM_HOLES      = 8,
  parameter int ROUNDS         = 16,
  parameter int START_INTERVAL = 5,
  parameter int MIN_INTERVAL   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit,
  input  logic                 tmr_timeout,
  output logic [2:0]           tmr_interval,
  output logic                 tmr_dir,
  output logic                 tmr_restart,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic [7:0]           round_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int HW = (NUM_HOLES > 2) ? $clog2(NUM_HOLES) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [7:0]           lfsr_reg, lfsr_next;
  logic [HW-1:0]        hole_reg, hole_next, hole_pick;
  logic [1:0]           show_cnt_reg, show_cnt_next;
  logic [7:0]           score_reg, score_next;
  logic [7:0]           misses_reg, misses_next;
  logic [7:0]           round_reg, round_next;
  logic [2:0]           interval_reg, interval_next;
  logic [NUM_HOLES-1:0] mole_reg, mole_next;
  logic                 restart_reg, busy_reg, done_reg;
  logic                 hit_mole, hit_any;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1 (tap mask 0xB8)
  assign lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);

`ifdef MOLE_CTRL_NO_REPEAT_EN
  logic [HW-1:0] prev_hole_reg;

  // Bump to the neighbouring hole (wrapping) when the raw pick repeats
  always_comb begin
    hole_pick = lfsr_reg[HW-1:0];
    if (hole_pick == prev_hole_reg) hole_pick = hole_pick + 1'b1;
  end

  // Previous-hole memory survives start; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)                    prev_hole_reg <= '0;
    else if (state_reg == ST_ARM) prev_hole_reg <= hole_pick;
  end
`else
  assign hole_pick = lfsr_reg[HW-1:0];
`endif

  assign hit_mole = |(hit & mole_reg);
  assign hit_any  = |hit;

  // Next-state and datapath update; outputs are derived from state_next so they register cleanly
  always_comb begin
    state_next    = state_reg;
    hole_next     = hole_reg;
    show_cnt_next = show_cnt_reg;
    score_next    = score_reg;
    misses_next   = misses_reg;
    round_next    = round_reg;
    interval_next = interval_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          score_next    = 8'd0;
          misses_next   = 8'd0;
          round_next    = 8'd0;
          interval_next = 3'(START_INTERVAL);
          state_next    = ST_ARM;
        end
      end
      ST_ARM: begin
        hole_next     = hole_pick;
        show_cnt_next = 2'd0;
        state_next    = ST_SHOW;
      end
      ST_SHOW: begin
        // Counter saturates at 2: that is all the timeout blanking needs
        if (show_cnt_reg != 2'd2) show_cnt_next = show_cnt_reg + 2'd1;
        if (hit_mole) begin
          if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
          if (interval_reg != 3'(MIN_INTERVAL)) interval_next = interval_reg - 3'd1;
          state_next = ST_RESULT;
        end else if (hit_any) begin
          if (misses_reg != 8'hFF) misses_next = misses_reg + 8'd1;
          state_next = ST_RESULT;
        end else if (tmr_timeout && (show_cnt_reg == 2'd2)) begin
          if (misses_reg != 8'hFF) misses_next = misses_reg + 8'd1;
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (round_reg == 8'(ROUNDS - 1)) begin
          state_next = ST_DONE;
        end else begin
          round_next = round_reg + 8'd1;
          state_next = ST_ARM;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    mole_next = (state_next == ST_SHOW) ? (NUM_HOLES'(1) << hole_next) : '0;
  end

  // State and registered outputs; the LFSR free-runs so start timing adds entropy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lfsr_reg     <= 8'hA5;
      hole_reg     <= '0;
      show_cnt_reg <= 2'd0;
      score_reg    <= 8'd0;
      misses_reg   <= 8'd0;
      round_reg    <= 8'd0;
      interval_reg <= 3'(START_INTERVAL);
      mole_reg     <= '0;
      restart_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      hole_reg     <= hole_next;
      show_cnt_reg <= show_cnt_next;
      score_reg    <= score_next;
      misses_reg   <= misses_next;
      round_reg    <= round_next;
      interval_reg <= interval_next;
      mole_reg     <= mole_next;
      restart_reg  <= !((state_next == ST_SHOW) || (state_next == ST_RESULT));
      busy_reg     <= (state_next != ST_IDLE);
      done_reg     <= (state_next == ST_DONE);
    end
  end

  assign tmr_interval = interval_reg;
  assign tmr_dir      = 1'b0;
  assign tmr_restart  = restart_reg;
  assign mole         = mole_reg;
  assign score        = score_reg;
  assign misses       = misses_reg;
  assign round_idx    = round_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl (ROUNDS=4). Stimulus pushes the expected
// lit hole / lit duration and the expected end-of-game tallies; a monitor pops
// them when the DUT lights a mole or pulses done.
module tb_mole_round_ctrl;

  localparam int NH = 8;
  localparam int RN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] hit = 8'd0;
  logic       tmr_timeout = 1'b0;
  logic [2:0] tmr_interval;
  logic       tmr_dir, tmr_restart, busy, done;
  logic [7:0] mole, score, misses, round_idx;

  mole_round_ctrl #(.NUM_HOLES(NH), .ROUNDS(RN), .START_INTERVAL(5), .MIN_INTERVAL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .tmr_timeout(tmr_timeout),
    .tmr_interval(tmr_interval), .tmr_dir(tmr_dir), .tmr_restart(tmr_restart),
    .mole(mole), .score(score), .misses(misses), .round_idx(round_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] m; int dur; } mole_exp_t;
  typedef struct { logic [7:0] sc; logic [7:0] mi; logic [7:0] ri; logic [2:0] iv; } done_exp_t;

  mole_exp_t mole_q[$];
  done_exp_t done_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Golden LFSR, written tap by tap: x^8+x^6+x^5+x^4+1, seed A5
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[0], m_lfsr[7], m_lfsr[6] ^ m_lfsr[0], m_lfsr[5] ^ m_lfsr[0],
                    m_lfsr[4] ^ m_lfsr[0], m_lfsr[3], m_lfsr[2], m_lfsr[1]};
  end

`ifdef MOLE_CTRL_NO_REPEAT_EN
  logic [2:0] m_prev = 3'd0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called during an ARM cycle: predict the lit hole from the model LFSR
  task automatic push_mole(input int dur, output logic [7:0] m);
    logic [2:0] h;
    mole_exp_t e;
    h = m_lfsr[2:0];
`ifdef MOLE_CTRL_NO_REPEAT_EN
    if (h == m_prev) h = h + 3'd1;
    m_prev = h;
`endif
    m = 8'd1 << h;
    e.m = m;
    e.dur = dur;
    mole_q.push_back(e);
  endtask

  // kind: 0 hit@2, 1 timeout@50, 2 hit+timeout@2, 3 wrong@2 (+stray start),
  //       4 timeouts@0,1 then hit@4, 5 right+wrong@2
  task automatic play_round(input int kind);
    logic [7:0] m;
    int h;
    h = (kind == 1) ? 50 : (kind == 4) ? 4 : 2;
    push_mole(h + 1, m);
    for (int i = 0; i <= h; i++) begin
      tick();
      hit = 8'd0;
      tmr_timeout = 1'b0;
      start = 1'b0;
      if (kind == 4 && i < 2) tmr_timeout = 1'b1;
      if (kind == 3 && i == 0) start = 1'b1;
      if (i == h) begin
        case (kind)
          0, 4: hit = m;
          1: tmr_timeout = 1'b1;
          2: begin hit = m; tmr_timeout = 1'b1; end
          3: hit = {m[6:0], m[7]};
          default: hit = m | {m[6:0], m[7]};
        endcase
      end
    end
    tick();  // RESULT
    hit = 8'd0;
    tmr_timeout = 1'b0;
    tick();  // next ARM or DONE
  endtask

  task automatic play_game(input int kinds[RN], input logic [7:0] sc, input logic [7:0] mi,
                           input logic [2:0] iv, input string tag);
    done_exp_t d;
    d.sc = sc; d.mi = mi; d.ri = 8'(RN - 1); d.iv = iv;
    done_q.push_back(d);
    start = 1'b1;
    tick();  // ARM
    start = 1'b0;
    check({tag, "_busy_in_arm"}, busy, 1);
    for (int r = 0; r < RN; r++) play_round(kinds[r]);
    tick();  // back in IDLE
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
  endtask

  // Monitor: compare lit hole and lit duration, and tallies on done
  initial begin
    logic [7:0] prev_mole;
    mole_exp_t cur;
    done_exp_t d;
    int lit_cnt;
    bit lit_on;
    prev_mole = 8'd0;
    lit_cnt = 0;
    lit_on = 1'b0;
    cur.m = 8'd0;
    cur.dur = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mole = 8'd0;
        lit_on = 1'b0;
      end else begin
        if (mole != 8'd0 && prev_mole == 8'd0) begin
          if (mole_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mole: got %0h expected none", mole);
          end else begin
            cur = mole_q.pop_front();
            check("mole_hole", mole, cur.m);
            lit_on = 1'b1;
            lit_cnt = 0;
          end
        end
        if (lit_on && mole != 8'd0) lit_cnt++;
        if (lit_on && mole == 8'd0) begin
          if (cur.dur >= 0) check("mole_lit_cycles", lit_cnt, cur.dur);
          lit_on = 1'b0;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            d = done_q.pop_front();
            check("done_score", score, d.sc);
            check("done_misses", misses, d.mi);
            check("done_round_idx", round_idx, d.ri);
            check("done_interval", tmr_interval, d.iv);
          end
        end
        prev_mole = mole;
      end
    end
  end

  initial begin
    int g1[RN] = '{0, 0, 0, 0};
    int g2[RN] = '{1, 1, 1, 1};
    int g3[RN] = '{2, 3, 4, 5};
    logic [7:0] m;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_round", round_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_restart", tmr_restart, 1);
    check("rst_interval", tmr_interval, 5);
    check("rst_dir", tmr_dir, 0);
    rst = 1'b0;

    // Idle with stray hit pulses
    for (int i = 0; i < 100; i++) begin
      hit = (i % 10 == 3) ? 8'hFF : 8'd0;
      tick();
    end
    hit = 8'd0;
    tick();
    check("idle_mole", mole, 0);
    check("idle_restart", tmr_restart, 1);
    check("idle_busy", busy, 0);
    check("idle_score", score, 0);

    play_game(g1, 8'd4, 8'd0, 3'd1, "all_hits");
    repeat (7) tick();
    play_game(g2, 8'd0, 8'd4, 3'd5, "all_timeouts");
    repeat (3) tick();
    play_game(g3, 8'd3, 8'd1, 3'd2, "mixed");

    // Mid-game reset: score one hit, then abort in SHOW of round 2
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    play_round(0);
    push_mole(-1, m);
    tick();
    tick();
    check("abort_restart_show", tmr_restart, 0);
    rst = 1'b1;
    tick();
    check("abort_mole", mole, 0);
    check("abort_score", score, 0);
    check("abort_misses", misses, 0);
    check("abort_round", round_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_restart", tmr_restart, 1);
    check("abort_interval", tmr_interval, 5);
    rst = 1'b0;
`ifdef MOLE_CTRL_NO_REPEAT_EN
    m_prev = 3'd0;
`endif
    repeat (5) tick();
    check("abort_no_done_busy", busy, 0);

    check("mole_queue_drained", mole_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
